// File: rtl/warp_ctx_table_pkg.sv
// Shared GPU core types: warp status codes, completion opcodes and datapath widths.
package pkg_opengpu;

  localparam int unsigned WARPS_PER_CORE = 8;
  localparam int unsigned WARP_ID_WIDTH  = 3;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned WARP_SIZE      = 32;
  localparam int unsigned INSTR_BYTES    = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReady   = 3'd1,
    StPending = 3'd2,
    StBarrier = 3'd3,
    StDone    = 3'd4
  } warp_status_t;

  typedef enum logic [1:0] {
    OpNext    = 2'd0,
    OpBranch  = 2'd1,
    OpBarrier = 2'd2,
    OpExit    = 2'd3
  } upd_op_t;

endpackage

// File: rtl/warp_barrier_sync.sv
// Detects a core-wide barrier (every live warp parked at BARRIER or DONE, at least one
// at BARRIER) and emits a one-cycle registered release pulse.
module warp_barrier_sync
  import pkg_opengpu::*;
#(
  parameter int unsigned NUM_WARPS = WARPS_PER_CORE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_WARPS*3-1:0] i_status,
  output logic                   o_release
);

  logic w_any_barrier;
  logic w_all_parked;
  logic r_release;

  // IDLE slots were never launched and do not take part in the barrier.
  always_comb begin
    w_any_barrier = 1'b0;
    w_all_parked  = 1'b1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (i_status[i*3 +: 3] == StBarrier) begin
        w_any_barrier = 1'b1;
      end else if ((i_status[i*3 +: 3] != StIdle) && (i_status[i*3 +: 3] != StDone)) begin
        w_all_parked = 1'b0;
      end
    end
  end

  // Held low for the cycle after a pulse so a stale condition cannot fire twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_release <= 1'b0;
    end else begin
      r_release <= w_any_barrier && w_all_parked && !r_release;
    end
  end

  assign o_release = r_release;

endmodule

// File: rtl/warp_ctx_table.sv
// Per-warp context table (PC, mask, status, age) feeding the warp scheduler.
// Build option WARP_CTX_ZERO_MASK_EXIT_EN: a BRANCH leaving no active lanes retires the warp.
module warp_ctx_table
  import pkg_opengpu::*;
#(
  parameter int unsigned NUM_WARPS = WARPS_PER_CORE,
  parameter int unsigned AGE_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            launch_valid,
  output logic                            launch_ready,
  input  logic [WARP_ID_WIDTH-1:0]        launch_warp_id,
  input  logic [DATA_WIDTH-1:0]           launch_pc,
  input  logic [WARP_SIZE-1:0]            launch_mask,
  input  logic                            issue_ack,
  input  logic [WARP_ID_WIDTH-1:0]        issue_warp_id,
  input  logic                            upd_valid,
  input  logic [WARP_ID_WIDTH-1:0]        upd_warp_id,
  input  logic [1:0]                      upd_op,
  input  logic [DATA_WIDTH-1:0]           upd_pc,
  input  logic [WARP_SIZE-1:0]            upd_mask,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] ctx_pc,
  output logic [NUM_WARPS*WARP_SIZE-1:0]  ctx_mask,
  output logic [NUM_WARPS*3-1:0]          ctx_status,
  output logic [NUM_WARPS*AGE_WIDTH-1:0]  ctx_age,
  output logic [NUM_WARPS-1:0]            ctx_valid,
  output logic                            err_illegal
);

  logic [DATA_WIDTH-1:0] r_pc     [NUM_WARPS];
  logic [WARP_SIZE-1:0]  r_mask   [NUM_WARPS];
  warp_status_t          r_status [NUM_WARPS];
  logic [AGE_WIDTH-1:0]  r_age    [NUM_WARPS];
  logic [NUM_WARPS-1:0]  r_valid;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] w_pc_d     [NUM_WARPS];
  logic [WARP_SIZE-1:0]  w_mask_d   [NUM_WARPS];
  warp_status_t          w_status_d [NUM_WARPS];
  logic [AGE_WIDTH-1:0]  w_age_d    [NUM_WARPS];
  logic [NUM_WARPS-1:0]  w_valid_d;
  logic                  w_err_d;

  logic [NUM_WARPS-1:0]  w_launch_hit;
  logic [NUM_WARPS-1:0]  w_issue_hit;
  logic [NUM_WARPS-1:0]  w_upd_hit;
  logic                  w_issue_ok;
  logic                  w_upd_ok;
  logic                  w_release;

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_launch_hit[i] = (launch_warp_id == WARP_ID_WIDTH'(i));
      w_issue_hit[i]  = (issue_warp_id == WARP_ID_WIDTH'(i));
      w_upd_hit[i]    = (upd_warp_id == WARP_ID_WIDTH'(i));
    end
  end

  always_comb begin
    launch_ready = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w_launch_hit[i] && ((r_status[i] == StIdle) || (r_status[i] == StDone))) begin
        launch_ready = 1'b1;
      end
    end
  end

  // Each status admits exactly one kind of event, so no priority between them is needed.
  always_comb begin
    w_issue_ok = 1'b0;
    w_upd_ok   = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_pc_d[i]     = r_pc[i];
      w_mask_d[i]   = r_mask[i];
      w_status_d[i] = r_status[i];
      w_age_d[i]    = r_age[i];
      w_valid_d[i]  = r_valid[i];
      unique case (r_status[i])
        StIdle, StDone: begin
          if (launch_valid && w_launch_hit[i]) begin
            w_pc_d[i]     = launch_pc;
            w_mask_d[i]   = launch_mask;
            w_status_d[i] = StReady;
            w_age_d[i]    = '0;
            w_valid_d[i]  = 1'b1;
          end
        end
        StReady: begin
          if (issue_ack && w_issue_hit[i]) begin
            w_issue_ok    = 1'b1;
            w_status_d[i] = StPending;
            w_age_d[i]    = '0;
          end else if (r_age[i] != {AGE_WIDTH{1'b1}}) begin
            w_age_d[i] = r_age[i] + AGE_WIDTH'(1);
          end
        end
        StPending: begin
          if (upd_valid && w_upd_hit[i]) begin
            w_upd_ok = 1'b1;
            unique case (upd_op_t'(upd_op))
              OpNext: begin
                w_pc_d[i]     = r_pc[i] + DATA_WIDTH'(INSTR_BYTES);
                w_status_d[i] = StReady;
              end
              OpBranch: begin
                w_pc_d[i]   = upd_pc;
                w_mask_d[i] = upd_mask;
`ifdef WARP_CTX_ZERO_MASK_EXIT_EN
                w_status_d[i] = (upd_mask == '0) ? StDone : StReady;
`else
                w_status_d[i] = StReady;
`endif
              end
              OpBarrier: begin
                w_pc_d[i]     = r_pc[i] + DATA_WIDTH'(INSTR_BYTES);
                w_status_d[i] = StBarrier;
              end
              OpExit: begin
                w_status_d[i] = StDone;
              end
            endcase
          end
        end
        StBarrier: begin
          if (w_release) begin
            w_status_d[i] = StReady;
            w_age_d[i]    = '0;
          end
        end
        default: ;
      endcase
    end
    w_err_d = r_err || (issue_ack && !w_issue_ok) || (upd_valid && !w_upd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        r_pc[i]     <= '0;
        r_mask[i]   <= '0;
        r_status[i] <= StIdle;
        r_age[i]    <= '0;
      end
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        r_pc[i]     <= w_pc_d[i];
        r_mask[i]   <= w_mask_d[i];
        r_status[i] <= w_status_d[i];
        r_age[i]    <= w_age_d[i];
      end
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    ctx_pc     = '0;
    ctx_mask   = '0;
    ctx_status = '0;
    ctx_age    = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      ctx_pc[i*DATA_WIDTH +: DATA_WIDTH] = r_pc[i];
      ctx_mask[i*WARP_SIZE +: WARP_SIZE] = r_mask[i];
      ctx_status[i*3 +: 3]               = r_status[i];
      ctx_age[i*AGE_WIDTH +: AGE_WIDTH]  = r_age[i];
    end
  end

  assign ctx_valid   = r_valid;
  assign err_illegal = r_err;

  warp_barrier_sync #(
    .NUM_WARPS (NUM_WARPS)
  ) u_barrier_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_status  (ctx_status),
    .o_release (w_release)
  );

endmodule

// File: tb/tb_warp_ctx_table.sv
// Scoreboard bench for warp_ctx_table: a behavioural warp model predicts the context after
// every clock edge and a monitor compares the DUT against the queued predictions.
module tb_warp_ctx_table;

  localparam int N  = 8;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WS = 32;
  localparam int IW = 3;
  localparam int AGE_MAX = (1 << AW) - 1;
  localparam int ST_IDLE = 0, ST_READY = 1, ST_PENDING = 2, ST_BARRIER = 3, ST_DONE = 4;
  localparam int OP_NEXT = 0, OP_BRANCH = 1, OP_BARRIER = 2, OP_EXIT = 3;
`ifdef WARP_CTX_ZERO_MASK_EXIT_EN
  localparam bit ZERO_MASK_EXIT = 1'b1;
`else
  localparam bit ZERO_MASK_EXIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          launch_valid = 1'b0;
  logic          launch_ready;
  logic [IW-1:0] launch_warp_id = '0;
  logic [DW-1:0] launch_pc = '0;
  logic [WS-1:0] launch_mask = '0;
  logic          issue_ack = 1'b0;
  logic [IW-1:0] issue_warp_id = '0;
  logic          upd_valid = 1'b0;
  logic [IW-1:0] upd_warp_id = '0;
  logic [1:0]    upd_op = '0;
  logic [DW-1:0] upd_pc = '0;
  logic [WS-1:0] upd_mask = '0;
  logic [N*DW-1:0] ctx_pc;
  logic [N*WS-1:0] ctx_mask;
  logic [N*3-1:0]  ctx_status;
  logic [N*AW-1:0] ctx_age;
  logic [N-1:0]    ctx_valid;
  logic            err_illegal;

  always #5 clk = ~clk;

  warp_ctx_table #(
    .NUM_WARPS (N),
    .AGE_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .launch_valid   (launch_valid),
    .launch_ready   (launch_ready),
    .launch_warp_id (launch_warp_id),
    .launch_pc      (launch_pc),
    .launch_mask    (launch_mask),
    .issue_ack      (issue_ack),
    .issue_warp_id  (issue_warp_id),
    .upd_valid      (upd_valid),
    .upd_warp_id    (upd_warp_id),
    .upd_op         (upd_op),
    .upd_pc         (upd_pc),
    .upd_mask       (upd_mask),
    .ctx_pc         (ctx_pc),
    .ctx_mask       (ctx_mask),
    .ctx_status     (ctx_status),
    .ctx_age        (ctx_age),
    .ctx_valid      (ctx_valid),
    .err_illegal    (err_illegal)
  );

  typedef struct {
    logic [N*DW-1:0] pc;
    logic [N*WS-1:0] mask;
    logic [N*3-1:0]  status;
    logic [N*AW-1:0] age;
    logic [N-1:0]    valid;
    logic            err;
    logic            lrdy;
  } snap_t;

  snap_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_status[N];
  logic [31:0] m_pc[N];
  logic [31:0] m_mask[N];
  int          m_age[N];
  bit          m_valid[N];
  bit          m_flag;
  bit          m_err;

  // Stimulus for the next cycle
  bit d_rst, d_lv, d_ia, d_uv;
  int d_lid, d_iid, d_uid, d_op;
  logic [31:0] d_lpc, d_lmask, d_upc, d_umask;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_status[i] = ST_IDLE;
      m_pc[i]     = '0;
      m_mask[i]   = '0;
      m_age[i]    = 0;
      m_valid[i]  = 1'b0;
    end
    m_flag = 1'b0;
    m_err  = 1'b0;
  endfunction

  // One clock edge of the warp rules, evaluated on the pre-edge state.
  function automatic void model_step();
    int          n_status[N];
    logic [31:0] n_pc[N];
    logic [31:0] n_mask[N];
    int          n_age[N];
    bit          n_valid[N];
    bit          any_bar, all_parked;
    if (!d_rst) begin
      model_reset();
      return;
    end
    n_status = m_status;
    n_pc     = m_pc;
    n_mask   = m_mask;
    n_age    = m_age;
    n_valid  = m_valid;
    if (d_lv && (m_status[d_lid] == ST_IDLE || m_status[d_lid] == ST_DONE)) begin
      n_pc[d_lid]     = d_lpc;
      n_mask[d_lid]   = d_lmask;
      n_status[d_lid] = ST_READY;
      n_age[d_lid]    = 0;
      n_valid[d_lid]  = 1'b1;
    end
    if (d_ia) begin
      if (m_status[d_iid] == ST_READY) begin
        n_status[d_iid] = ST_PENDING;
        n_age[d_iid]    = 0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (d_uv) begin
      if (m_status[d_uid] == ST_PENDING) begin
        case (d_op)
          OP_NEXT: begin
            n_pc[d_uid] = m_pc[d_uid] + 32'd4;
            n_status[d_uid] = ST_READY;
          end
          OP_BRANCH: begin
            n_pc[d_uid]   = d_upc;
            n_mask[d_uid] = d_umask;
            n_status[d_uid] = (ZERO_MASK_EXIT && d_umask == 0) ? ST_DONE : ST_READY;
          end
          OP_BARRIER: begin
            n_pc[d_uid] = m_pc[d_uid] + 32'd4;
            n_status[d_uid] = ST_BARRIER;
          end
          default: n_status[d_uid] = ST_DONE;
        endcase
      end else begin
        m_err = 1'b1;
      end
    end
    any_bar    = 1'b0;
    all_parked = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m_flag && m_status[i] == ST_BARRIER) begin
        n_status[i] = ST_READY;
        n_age[i]    = 0;
      end
      if (m_status[i] == ST_READY && !(d_ia && d_iid == i)) begin
        n_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
      end
      if (m_valid[i] && m_status[i] == ST_BARRIER) any_bar = 1'b1;
      if (m_valid[i] && m_status[i] != ST_BARRIER && m_status[i] != ST_DONE) all_parked = 1'b0;
    end
    m_flag   = any_bar && all_parked;
    m_status = n_status;
    m_pc     = n_pc;
    m_mask   = n_mask;
    m_age    = n_age;
    m_valid  = n_valid;
  endfunction

  function automatic snap_t snapshot();
    snap_t s;
    for (int i = 0; i < N; i++) begin
      s.pc[i*DW +: DW]   = m_pc[i];
      s.mask[i*WS +: WS] = m_mask[i];
      s.status[i*3 +: 3] = 3'(m_status[i]);
      s.age[i*AW +: AW]  = AW'(m_age[i]);
      s.valid[i]         = m_valid[i];
    end
    s.err  = m_err;
    s.lrdy = (m_status[d_lid] == ST_IDLE) || (m_status[d_lid] == ST_DONE);
    return s;
  endfunction

  task automatic step();
    @(negedge clk);
    rst_n          = d_rst;
    launch_valid   = d_lv;
    launch_warp_id = IW'(d_lid);
    launch_pc      = d_lpc;
    launch_mask    = d_lmask;
    issue_ack      = d_ia;
    issue_warp_id  = IW'(d_iid);
    upd_valid      = d_uv;
    upd_warp_id    = IW'(d_uid);
    upd_op         = 2'(d_op);
    upd_pc         = d_upc;
    upd_mask       = d_umask;
    model_step();
    sb_q.push_back(snapshot());
    d_lv = 1'b0;
    d_ia = 1'b0;
    d_uv = 1'b0;
  endtask

  task automatic launch(input int id, input logic [31:0] pc);
    d_lv = 1'b1; d_lid = id; d_lpc = pc; d_lmask = 32'hFFFF_FFFF;
    step();
  endtask

  task automatic issue(input int id);
    d_ia = 1'b1; d_iid = id;
    step();
  endtask

  task automatic update(input int id, input int op, input logic [31:0] pc, input logic [31:0] mask);
    d_uv = 1'b1; d_uid = id; d_op = op; d_upc = pc; d_umask = mask;
    step();
  endtask

  task automatic sync_reset();
    d_rst = 1'b0;
    step();
    d_rst = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic int pick(input int want);
    int s;
    s = $urandom_range(N - 1);
    for (int k = 0; k < N; k++) begin
      if (m_status[(s + k) % N] == want) return (s + k) % N;
    end
    return -1;
  endfunction

  // Monitor: every clock edge (and asynchronous reset) consumes one prediction.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < N; i++) begin
          chk($sformatf("pc[%0d]", i), ctx_pc[i*DW +: DW], e.pc[i*DW +: DW]);
          chk($sformatf("mask[%0d]", i), ctx_mask[i*WS +: WS], e.mask[i*WS +: WS]);
          chk($sformatf("status[%0d]", i), 32'(ctx_status[i*3 +: 3]), 32'(e.status[i*3 +: 3]));
          chk($sformatf("age[%0d]", i), 32'(ctx_age[i*AW +: AW]), 32'(e.age[i*AW +: AW]));
          chk($sformatf("valid[%0d]", i), 32'(ctx_valid[i]), 32'(e.valid[i]));
        end
        chk("err_illegal", 32'(err_illegal), 32'(e.err));
        chk("launch_ready", 32'(launch_ready), 32'(e.lrdy));
      end
    end
  end

  initial begin
    int j, r;
    d_rst = 1'b0; d_lv = 1'b0; d_ia = 1'b0; d_uv = 1'b0;
    d_lid = 0; d_iid = 0; d_uid = 0; d_op = 0;
    d_lpc = '0; d_lmask = '0; d_upc = '0; d_umask = '0;
    model_reset();
    repeat (2) step();
    d_rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      d_lid = i;
      step();
    end

    // Launch of warp 2
    launch(2, 32'h100);
    settle();
    chk("launch_w2_status", 32'(ctx_status[6 +: 3]), ST_READY);
    chk("launch_w2_pc", ctx_pc[2*DW +: DW], 32'h100);
    chk("launch_w2_age", 32'(ctx_age[2*AW +: AW]), 0);
    chk("launch_w2_ready", 32'(launch_ready), 0);

    // Age saturation then issue
    repeat (300) step();
    settle();
    chk("age_w2_saturated", 32'(ctx_age[2*AW +: AW]), 255);
    issue(2);
    settle();
    chk("issue_w2_status", 32'(ctx_status[6 +: 3]), ST_PENDING);
    chk("issue_w2_age", 32'(ctx_age[2*AW +: AW]), 0);

    // PC wrap and branch on warp 1
    launch(1, 32'hFFFF_FFFC);
    issue(1);
    update(1, OP_NEXT, 32'h0, 32'h0);
    settle();
    chk("wrap_w1_pc", ctx_pc[1*DW +: DW], 32'h0);
    chk("wrap_w1_status", 32'(ctx_status[3 +: 3]), ST_READY);
    issue(1);
    update(1, OP_BRANCH, 32'h40, 32'h0000_FFFF);
    settle();
    chk("branch_w1_pc", ctx_pc[1*DW +: DW], 32'h40);
    chk("branch_w1_mask", ctx_mask[1*WS +: WS], 32'h0000_FFFF);
    chk("branch_no_err", 32'(err_illegal), 0);

    // Barrier release with the other live warp exiting
    sync_reset();
    launch(0, 32'h200);
    launch(1, 32'h300);
    issue(0);
    issue(1);
    update(0, OP_BARRIER, 32'h0, 32'h0);
    update(1, OP_EXIT, 32'h0, 32'h0);
    d_lid = 1;
    step();
    settle();
    chk("bar_w0_still_waiting", 32'(ctx_status[0 +: 3]), ST_BARRIER);
    step();
    settle();
    chk("bar_w0_released", 32'(ctx_status[0 +: 3]), ST_READY);
    chk("bar_w0_age", 32'(ctx_age[0 +: AW]), 0);
    chk("bar_w0_pc", ctx_pc[0 +: DW], 32'h204);
    chk("bar_w1_done", 32'(ctx_status[3 +: 3]), ST_DONE);
    chk("bar_w1_launch_ready", 32'(launch_ready), 1);

    // Update to a READY warp is illegal and sticky
    sync_reset();
    launch(3, 32'h80);
    update(3, OP_NEXT, 32'h0, 32'h0);
    settle();
    chk("illegal_w3_pc", ctx_pc[3*DW +: DW], 32'h80);
    chk("illegal_w3_status", 32'(ctx_status[9 +: 3]), ST_READY);
    chk("illegal_err_set", 32'(err_illegal), 1);
    repeat (5) step();
    settle();
    chk("illegal_err_sticky", 32'(err_illegal), 1);

    // Asynchronous reset while warps are mid-flight and one waits at a barrier
    sync_reset();
    launch(0, 32'h10);
    launch(1, 32'h20);
    launch(2, 32'h30);
    issue(0);
    issue(1);
    issue(2);
    update(0, OP_BARRIER, 32'h0, 32'h0);
    settle();
    d_rst = 1'b0;
    model_reset();
    sb_q.push_back(snapshot());
    rst_n = 1'b0;
    #1;
    chk("async_rst_status", 32'(ctx_status), 0);
    chk("async_rst_valid", 32'(ctx_valid), 0);
    chk("async_rst_pc0", ctx_pc[0 +: DW], 0);
    chk("async_rst_mask1", ctx_mask[1*WS +: WS], 0);
    step();
    d_rst = 1'b1;

    // Randomised traffic with occasional illegal requests and periodic resets
    for (int c = 0; c < 3000; c++) begin
      d_rst = (c % 400) != 399;
      if ($urandom_range(3) == 0) begin
        d_lv = 1'b1; d_lid = $urandom_range(N - 1);
        d_lpc = $urandom; d_lmask = $urandom;
      end
      if ($urandom_range(3) != 0) begin
        j = pick(ST_READY);
        if ($urandom_range(99) < 2) j = $urandom_range(N - 1);
        if (j >= 0) begin d_ia = 1'b1; d_iid = j; end
      end
      if ($urandom_range(3) != 0) begin
        j = pick(ST_PENDING);
        if ($urandom_range(99) < 2) j = $urandom_range(N - 1);
        if (j >= 0) begin
          r = $urandom_range(99);
          d_uv = 1'b1; d_uid = j;
          d_op = (r < 40) ? OP_NEXT : (r < 65) ? OP_BRANCH : (r < 90) ? OP_BARRIER : OP_EXIT;
          d_upc = $urandom;
          d_umask = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
        end
      end
      step();
    end
    d_rst = 1'b1;
    repeat (3) step();
    settle();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
